photon_event_tagger: RTL and testbench

PHOTON_EVENT_TAGGER -- requirements
Module: photon_event_tagger

---
 rtl/photon_event_tagger.sv | 105 ++++++++++
 tb/tb_photon_event_tagger.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/photon_event_tagger.sv
// Photon event tagger: detects rising edges on detector channels, tags each
// event with the current timestamp and buffers {chmask, timestamp} entries in a
// first-word-fall-through FIFO. Events arriving while the FIFO is full are dropped
// and counted in a saturating overflow counter.
module photon_event_tagger #(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          run,
   input  logic [63:0]                   timestamp,
   input  logic [NUM_CH-1:0]             pulse,
   input  logic                          clear,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [63:0]                   m_timestamp,
   output logic [NUM_CH-1:0]             m_chmask,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [31:0]                   overflow_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DepthL = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] PtrOne = (AW+1)'(1);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [NUM_CH-1:0] prev_q, prev_d;
   logic [31:0]       ovf_q, ovf_d;

   logic [63:0]       mem_ts_q [FIFO_DEPTH];
   logic [NUM_CH-1:0] mem_ch_q [FIFO_DEPTH];

   logic [NUM_CH-1:0] rise;
   logic              evt;
   logic [AW:0]       level;
   logic              full;
   logic              empty;
   logic              xfer;
   logic              wr_en;
   logic              drop;

   // Event detection, FIFO control and next-state computation.
   always_comb begin
      rise     = pulse & ~prev_q;
      evt      = run && (rise != '0);
      level    = wr_ptr_q - rd_ptr_q;
      full     = (level == DepthL);
      empty    = (level == '0);
      xfer     = !empty && m_ready;
      // A full FIFO still accepts an event when the head leaves on the same edge.
      wr_en    = evt && (!full || xfer) && !clear;
      drop     = evt && full && !xfer && !clear;

      prev_d   = pulse;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;

      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         ovf_d    = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + PtrOne;
         if (xfer)  rd_ptr_d = rd_ptr_q + PtrOne;
         if (drop && (ovf_q != 32'hFFFF_FFFF)) ovf_d = ovf_q + 32'd1;
      end
   end

   // Control state; prev resets high so a pulse already high at release is not an event.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         prev_q   <= '1;
         ovf_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         prev_q   <= prev_d;
         ovf_q    <= ovf_d;
      end
   end

   // Entry storage; contents are meaningless outside the pointer window so no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_ts_q[wr_ptr_q[AW-1:0]] <= timestamp;
         mem_ch_q[wr_ptr_q[AW-1:0]] <= rise;
      end
   end

   // Head outputs are forced to zero when empty so reset/clear present clean zeros.
   always_comb begin
      m_valid        = !empty;
      m_timestamp    = empty ? '0 : mem_ts_q[rd_ptr_q[AW-1:0]];
      m_chmask       = empty ? '0 : mem_ch_q[rd_ptr_q[AW-1:0]];
      fifo_level     = level;
      overflow_count = ovf_q;
   end

endmodule

// File: tb/tb_photon_event_tagger.sv
// Bench for photon_event_tagger: directed scenarios followed by random traffic,
// all checked each cycle against a queue-based reference model.
module tb_photon_event_tagger;

   localparam int unsigned NCH = 4;
   localparam int unsigned DEPTH = 8;

   logic              clk = 1'b0;
   logic              resetn;
   logic              run;
   logic [63:0]       timestamp;
   logic [NCH-1:0]    pulse;
   logic              clear;
   logic              m_valid;
   logic              m_ready;
   logic [63:0]       m_timestamp;
   logic [NCH-1:0]    m_chmask;
   logic [3:0]        fifo_level;
   logic [31:0]       overflow_count;

   photon_event_tagger #(.NUM_CH(NCH), .FIFO_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .run            (run),
      .timestamp      (timestamp),
      .pulse          (pulse),
      .clear          (clear),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .m_timestamp    (m_timestamp),
      .m_chmask       (m_chmask),
      .fifo_level     (fifo_level),
      .overflow_count (overflow_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NCH-1:0] mask;
      logic [63:0]    ts;
   } ent_t;

   ent_t           q[$];
   logic [NCH-1:0] m_prev;
   longint unsigned m_ovf;
   int             vectors = 0;
   int             miscompares = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf  = 0;
      m_prev = '1;
   endtask

   // Behavioural view of one clock edge using the inputs currently driven.
   task automatic model_edge();
      logic [NCH-1:0] r;
      bit             ev, tr;
      int             n;
      r  = pulse & ~m_prev;
      ev = run && (r != 0);
      n  = q.size();
      tr = (n > 0) && m_ready;
      if (clear) begin
         q.delete();
         m_ovf = 0;
      end else begin
         if (tr) void'(q.pop_front());
         if (ev) begin
            if (n < DEPTH || tr) q.push_back('{mask: r, ts: timestamp});
            else if (m_ovf < 64'hFFFF_FFFF) m_ovf++;
         end
      end
      m_prev = pulse;
   endtask

   task automatic check_all(input string tag);
      bit   nz;
      ent_t h;
      nz = (q.size() != 0);
      h  = nz ? q[0] : '0;
      chk({tag, ".valid"}, 64'(m_valid), 64'(nz));
      chk({tag, ".ts"},    m_timestamp, h.ts);
      chk({tag, ".mask"},  64'(m_chmask), 64'(h.mask));
      chk({tag, ".level"}, 64'(fifo_level), 64'(q.size()));
      chk({tag, ".ovf"},   64'(overflow_count), m_ovf);
   endtask

   task automatic step(input string tag, input logic r, input logic [NCH-1:0] p,
                       input logic rdy, input logic clr, input logic [63:0] ts);
      run = r; pulse = p; m_ready = rdy; clear = clr; timestamp = ts;
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      // Reset with channel 1 already high.
      resetn = 1'b0; run = 1'b0; pulse = 4'b0010; m_ready = 1'b0; clear = 1'b0;
      timestamp = '0;
      model_reset();
      #1;
      check_all("reset");
      repeat (2) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      step("held_at_release", 1, 4'b0010, 1, 0, 64'd5);

      // Single event.
      step("single_pre", 1, 4'b0000, 1, 0, 64'd99);
      step("single_rise", 1, 4'b0100, 1, 0, 64'd100);
      chk("single.ts100", m_timestamp, 64'd100);
      chk("single.mask", 64'(m_chmask), 64'h4);
      step("single_after", 1, 4'b0100, 1, 0, 64'd101);
      chk("single.gone", 64'(m_valid), 64'd0);

      // Coincidence on channels 0 and 3.
      step("coin_pre", 1, 4'b0000, 0, 0, 64'd56);
      step("coin", 1, 4'b1001, 0, 0, 64'd57);
      chk("coin.mask", 64'(m_chmask), 64'h9);
      chk("coin.level", 64'(fifo_level), 64'd1);

      // Overflow: ten rises with no consumer.
      step("ovf_clear", 1, 4'b0000, 0, 1, 64'd0);
      for (int i = 0; i < 10; i++) begin
         step("ovf_rise", 1, 4'b0001, 0, 0, 64'(1000 + 2 * i));
         step("ovf_fall", 1, 4'b0000, 0, 0, 64'(1001 + 2 * i));
      end
      chk("ovf.level8", 64'(fifo_level), 64'd8);
      chk("ovf.count2", 64'(overflow_count), 64'd2);
      for (int i = 0; i < 9; i++) step("ovf_drain", 1, 4'b0000, 1, 0, 64'd0);

      // Full FIFO with a transfer and an event on the same edge.
      step("full_clear", 1, 4'b0000, 0, 1, 64'd0);
      for (int i = 0; i < 8; i++) begin
         step("full_rise", 1, 4'b0010, 0, 0, 64'(200 + i));
         step("full_fall", 1, 4'b0000, 0, 0, 64'd0);
      end
      step("full_both", 1, 4'b0010, 1, 0, 64'd9999);
      chk("full.level8", 64'(fifo_level), 64'd8);
      chk("full.ovf0", 64'(overflow_count), 64'd0);
      for (int i = 0; i < 9; i++) step("full_drain", 1, 4'b0000, 1, 0, 64'd0);

      // Gating: rise while stopped, held high across run enable, rise while stopped.
      step("gate_clear", 0, 4'b0000, 0, 1, 64'd0);
      step("gate_r0", 0, 4'b1000, 0, 0, 64'd300);
      step("gate_hold", 1, 4'b1000, 0, 0, 64'd301);
      step("gate_low", 0, 4'b0000, 0, 0, 64'd302);
      step("gate_r0b", 0, 4'b0100, 0, 0, 64'd303);
      chk("gate.level0", 64'(fifo_level), 64'd0);

      // Clear mid-operation with event and transfer on the clear edge.
      for (int i = 0; i < 5; i++) begin
         step("clr_rise", 1, 4'b0001, 0, 0, 64'(400 + i));
         step("clr_fall", 1, 4'b0000, 0, 0, 64'd0);
      end
      step("clr_edge", 1, 4'b0001, 1, 1, 64'd500);
      chk("clr.level0", 64'(fifo_level), 64'd0);
      step("clr_after", 1, 4'b0000, 1, 0, 64'd501);

      // Asynchronous reset mid-operation.
      for (int i = 0; i < 5; i++) begin
         step("rst_rise", 1, 4'b0100, 0, 0, 64'(600 + i));
         step("rst_fall", 1, 4'b0000, 0, 0, 64'd0);
      end
      resetn = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk) resetn = 1'b1;
      step("rst_after", 1, 4'b0000, 1, 0, 64'd700);

      // Random traffic.
      for (int i = 0; i < 800; i++) begin
         step("rand",
              $urandom_range(0, 3) != 0,
              4'($urandom_range(0, 15)),
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 63) == 0,
              {$urandom, $urandom});
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
